// File: rtl/bound_buffer_pp.sv
// bound_buffer_pp: ping-pong store of per-character bounding boxes between segmentation and crop stages
//   aclk, aresetn          clock, asynchronous active-low reset
//   bound_y_*, *_we        y bounds written into the write bank
//   bound_x_*_addr/_/_we   x min/max halves of one entry, paired by the pair FSM
//   frame_done             swap banks and clear the new write bank
//   read, clr              present the next entry / restart the read sequence
//   bound_*_o, bound_valid presented entry of the read bank
//   char_count             valid entries in the read bank
//   read_done, pair_err    single-cycle status pulses
module bound_buffer_pp #(
  parameter int COORD_W  = 16,
  parameter int NUM_CHAR = 8,
  parameter int ADDR_W   = 3
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [COORD_W-1:0] bound_y_min,
  input  logic               bound_y_min_we,
  input  logic [COORD_W-1:0] bound_y_max,
  input  logic               bound_y_max_we,
  input  logic [ADDR_W-1:0]  bound_x_min_addr,
  input  logic [COORD_W-1:0] bound_x_min,
  input  logic               bound_x_min_we,
  input  logic [ADDR_W-1:0]  bound_x_max_addr,
  input  logic [COORD_W-1:0] bound_x_max,
  input  logic               bound_x_max_we,
  input  logic               frame_done,
  input  logic               read,
  input  logic               clr,
  output logic               bound_valid,
  output logic [ADDR_W-1:0]  bound_x_addr_o,
  output logic [COORD_W-1:0] bound_x_min_o,
  output logic [COORD_W-1:0] bound_x_max_o,
  output logic [COORD_W-1:0] bound_y_min_o,
  output logic [COORD_W-1:0] bound_y_max_o,
  output logic [ADDR_W:0]    char_count,
  output logic               read_done,
  output logic               pair_err
);
  typedef enum logic {WAIT_MIN, WAIT_MAX} state_t;
  localparam logic [ADDR_W:0] NC = (ADDR_W+1)'(NUM_CHAR);
  logic [COORD_W-1:0] xmin_m [2][NUM_CHAR];
  logic [COORD_W-1:0] xmax_m [2][NUM_CHAR];
  logic [NUM_CHAR-1:0] vld [2];
  logic [COORD_W-1:0] ymin_m [2];
  logic [COORD_W-1:0] ymax_m [2];
  logic wsel, rb;
  state_t state, nstate;
  logic [ADDR_W-1:0] cap_a, ncap_a, p_a, cm_a;
  logic [COORD_W-1:0] cap_v, ncap_v, p_v, cm_lo, cm_hi;
  logic cm_v, cm_b, commit, err, mn, mx, hit, clr_q, clr_rise;
  logic [ADDR_W:0] rd_ptr, cnt;
  logic [ADDR_W-1:0] ri;
  assign rb = ~wsel;
  assign ri = rd_ptr[ADDR_W-1:0];
  assign clr_rise = clr & ~clr_q;
  // out-of-range strobes are dropped here so the FSM never sees them
  assign mn = bound_x_min_we & ({1'b0, bound_x_min_addr} < NC);
  assign mx = bound_x_max_we & ({1'b0, bound_x_max_addr} < NC);
  // a min arriving this cycle supersedes any pending one as the pair partner
  assign p_a = mn ? bound_x_min_addr : cap_a;
  assign p_v = mn ? bound_x_min : cap_v;
  assign hit = bound_x_max_addr == p_a;
  always_comb begin
    nstate = state;
    ncap_a = cap_a;
    ncap_v = cap_v;
    err = (bound_x_min_we & ~mn) | (bound_x_max_we & ~mx);
    if (state == WAIT_MIN) begin
      commit = mn & mx & hit;
      err = err | (mx & ~(mn & hit));
      if (mn & ~mx) begin
        nstate = WAIT_MAX;
        ncap_a = bound_x_min_addr;
        ncap_v = bound_x_min;
      end
    end else begin
      commit = mx & hit;
      err = err | mn | (mx & ~hit);
      if (mn) begin
        ncap_a = bound_x_min_addr;
        ncap_v = bound_x_min;
      end
      if (mx) nstate = WAIT_MIN;
    end
    if (frame_done) nstate = WAIT_MIN;
  end
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_CHAR; i++) cnt = cnt + (ADDR_W+1)'(vld[rb][i]);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      xmin_m <= '{default: '0};
      xmax_m <= '{default: '0};
      vld <= '{default: '0};
      ymin_m <= '{default: '0};
      ymax_m <= '{default: '0};
    end else begin
      if (frame_done) begin
        vld[rb] <= '0;
        ymin_m[rb] <= '0;
        ymax_m[rb] <= '0;
      end
      if (bound_y_min_we) ymin_m[wsel] <= bound_y_min;
      if (bound_y_max_we) ymax_m[wsel] <= bound_y_max;
      // staged commit targets the bank captured with the strobe, even across a swap
      if (cm_v) begin
        xmin_m[cm_b][cm_a] <= cm_lo;
        xmax_m[cm_b][cm_a] <= cm_hi;
        vld[cm_b][cm_a] <= 1'b1;
      end
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= WAIT_MIN;
      cap_a <= '0;
      cap_v <= '0;
      cm_v <= 1'b0;
      cm_b <= 1'b0;
      cm_a <= '0;
      cm_lo <= '0;
      cm_hi <= '0;
      wsel <= 1'b0;
      clr_q <= 1'b0;
      rd_ptr <= '0;
      bound_valid <= 1'b0;
      bound_x_addr_o <= '0;
      bound_x_min_o <= '0;
      bound_x_max_o <= '0;
      bound_y_min_o <= '0;
      bound_y_max_o <= '0;
      char_count <= '0;
      read_done <= 1'b0;
      pair_err <= 1'b0;
    end else begin
      state <= nstate;
      cap_a <= ncap_a;
      cap_v <= ncap_v;
      cm_v <= commit;
      cm_b <= wsel;
      cm_a <= p_a;
      cm_lo <= p_v;
      cm_hi <= bound_x_max;
      pair_err <= err;
      clr_q <= clr;
      char_count <= cnt;
      read_done <= 1'b0;
      if (frame_done) wsel <= ~wsel;
      if (frame_done || clr_rise) begin
        rd_ptr <= '0;
        bound_valid <= 1'b0;
      end else if (read) begin
        if (rd_ptr < NC) begin
          bound_valid <= vld[rb][ri];
          bound_x_addr_o <= ri;
          bound_x_min_o <= xmin_m[rb][ri];
          bound_x_max_o <= xmax_m[rb][ri];
          bound_y_min_o <= ymin_m[rb];
          bound_y_max_o <= ymax_m[rb];
          rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
        end else begin
          read_done <= 1'b1;
          bound_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/bound_buffer_pp.md
Name: bound_buffer_pp

Overview:
Parametrised, double-buffered (ping-pong) store for per-character bounding boxes in the plate-recognition pipeline. It sits between the character segmentation stage, which writes x min/max pairs and y bounds, and the reorder/crop stage, which reads the boxes back one per `read` pulse. The segmenter fills one bank while the consumer reads the previous frame's bank. Compared with the single-bank buffer, it adds per-entry valid bits, pair-error reporting, an entry count and an end-of-sequence flag.

Parameters:
COORD_W, 16, width of every coordinate.
NUM_CHAR, 8, entries per bank; any value from 2 to 16 is allowed.
ADDR_W, 3, entry address width; must satisfy 2^ADDR_W >= NUM_CHAR.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
bound_y_min  in  COORD_W  top bound of the write bank
bound_y_min_we  in  1  write strobe for bound_y_min
bound_y_max  in  COORD_W  bottom bound of the write bank
bound_y_max_we  in  1  write strobe for bound_y_max
bound_x_min_addr  in  ADDR_W  entry index for the left bound
bound_x_min  in  COORD_W  left bound
bound_x_min_we  in  1  write strobe for the left bound
bound_x_max_addr  in  ADDR_W  entry index for the right bound
bound_x_max  in  COORD_W  right bound
bound_x_max_we  in  1  write strobe for the right bound
frame_done  in  1  single-cycle pulse: writer finished, swap banks
read  in  1  single-cycle pulse: present next entry
clr  in  1  rising edge restarts the read sequence
bound_valid  out  1  output registers hold a committed entry
bound_x_addr_o  out  ADDR_W  index of the presented entry
bound_x_min_o  out  COORD_W  left bound of the presented entry
bound_x_max_o  out  COORD_W  right bound of the presented entry
bound_y_min_o  out  COORD_W  read-bank y min
bound_y_max_o  out  COORD_W  read-bank y max
char_count  out  ADDR_W+1  number of valid entries in the read bank
read_done  out  1  one-cycle pulse on a read past the last entry
pair_err  out  1  one-cycle pulse on a malformed pair

Behaviour:
- Reset (asynchronous, immediate) clears:
  - all outputs to 0;
  - both banks: x arrays, valid masks and y registers;
  - write-bank select to 0 and rd_ptr to 0;
  - the pair FSM, which returns to WAIT_MIN.
- Storage: two banks, each holding x_min[NUM_CHAR], x_max[NUM_CHAR], valid[NUM_CHAR], y_min and y_max. The write bank is W; the read bank is the other one.
- Pair FSM in WAIT_MIN:
  - x_min_we alone: capture addr and value, go to WAIT_MAX.
  - x_min_we and x_max_we together with equal addr: commit directly, stay in WAIT_MIN.
  - x_min_we and x_max_we together with unequal addr: pair_err, stay.
  - x_max_we alone: pair_err, ignored.
- Pair FSM in WAIT_MAX:
  - x_max_we with addr equal to the captured addr: commit, go to WAIT_MIN.
  - x_max_we with a different addr: pair_err, discard, go to WAIT_MIN.
  - x_min_we: pair_err, the new min replaces the pending one, stay in WAIT_MAX.
- Address >= NUM_CHAR on either strobe: pair_err, write discarded.
- Commit: registered. The entry, with its valid bit set, is visible in bank W one cycle after the completing strobe.
- A commit pending at a frame_done edge lands in the bank that was W when the strobe arrived.
- y writes go to bank W on the strobe edge.
- frame_done, on the same edge:
  - W toggles.
  - The new W is cleared: valid mask and y set to 0.
  - The FSM returns to WAIT_MIN; any captured min is discarded without pair_err.
  - rd_ptr goes to 0 and bound_valid to 0.
  - char_count is updated on the next cycle to the popcount of the new read bank.
- Reads, when rd_ptr < NUM_CHAR, with 1-cycle latency from `read`:
  - outputs load entry rd_ptr of the read bank;
  - bound_valid is loaded from that entry's valid bit;
  - bound_y_min_o and bound_y_max_o load the read-bank y values;
  - rd_ptr increments.
- Read with rd_ptr == NUM_CHAR: read_done pulses, bound_valid goes to 0, the data outputs hold, rd_ptr saturates.
- clr: a rising edge (registered edge detect) sets rd_ptr to 0 and bound_valid to 0.
  - Precedence: frame_done over clr over read. The lower-priority event in the same cycle is ignored.
- Writes never disturb the read bank, so output data is stable across writer activity.

Test Plan:
- Reset; min(addr 2, 0x0010); max(addr 2, 0x0030); y_min 5; y_max 40; frame_done; 8 reads -> third output has addr 2, 0x10/0x30, bound_valid=1, y 5/40; other entries bound_valid=0; char_count=1; ninth read -> read_done pulse.
- min(addr 1) then max(addr 3) -> single pair_err pulse; after swap, char_count=0.
- Same-cycle min/max at addr 4 in WAIT_MIN -> committed, no pair_err. Commit with frame_done on the next edge -> entry appears in the new read bank.
- Frame A swapped; frame B written with different values during reads of A -> outputs show only A values. After a second frame_done -> B values.
- Two reads, clr rising edge, read -> output addr 0. clr and read in the same cycle -> read ignored.
- aresetn dropped mid-frame with no clock edge -> all outputs 0 immediately. After release, first read -> bound_valid=0, addr 0.
